// File: rtl/sigmoid_pkg.sv
//==============================================================================
// Module : sigmoid_pkg
// Brief  : Shared sizes and state encoding for the sigmoid register sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package sigmoid_pkg;
    localparam int NUM_NEURONS = 8;
    localparam int NUM_WEIGHTS = 10;
    localparam int TOTAL_REGS  = NUM_NEURONS + NUM_WEIGHTS;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 4;
    localparam int RD_W        = $clog2(NUM_NEURONS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, READ} seq_state_t;
endpackage

`default_nettype wire

// File: rtl/sigmoid_reg_sequencer_if.sv
//==============================================================================
// Module : sigmoid_reg_sequencer_if
// Brief  : Load stream, register-file bus and readback stream of the sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface sigmoid_reg_sequencer_if;
    import sigmoid_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_address;
    logic [DATA_W-1:0] reg_data_in;
    logic [DATA_W-1:0] reg_data_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  in_data, in_valid, reg_data_out, out_ready,
        output in_ready, reg_write_en, reg_address, reg_data_in, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, reg_data_out, out_ready,
        input  in_ready, reg_write_en, reg_address, reg_data_in, out_data, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/sigmoid_readback_slice.sv
//==============================================================================
// Module : sigmoid_readback_slice
// Brief  : One-entry valid/ready output register for the readback stream.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sigmoid_readback_slice
    import sigmoid_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              n_rst,
    input  wire logic              i_load,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_ready,
    output logic      [DATA_W-1:0] o_data,
    output logic                   o_valid
);
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // A held beat is only replaced when the caller has proven it was consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

`default_nettype wire

// File: rtl/sigmoid_reg_sequencer.sv
//==============================================================================
// Module : sigmoid_reg_sequencer
// Brief  : Loads the sigmoid register file from a stream, then reads neurons back.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module sigmoid_reg_sequencer
    import sigmoid_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  n_rst,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       done,
    sigmoid_reg_sequencer_if.master    bus
);
    localparam logic [1:0]        c_S_IDLE    = IDLE;
    localparam logic [1:0]        c_S_LOAD    = LOAD;
    localparam logic [1:0]        c_S_SETTLE  = SETTLE;
    localparam logic [1:0]        c_S_READ    = READ;
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(TOTAL_REGS - 1);
    localparam logic [RD_W-1:0]   c_RD_END    = RD_W'(NUM_NEURONS);
    localparam logic [RD_W-1:0]   c_RD_LAST   = RD_W'(NUM_NEURONS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [RD_W-1:0]   r_rd_ptr;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data_in;
    logic              r_done;

    logic              w_in_ready;
    logic              w_accept_in;
    logic              w_out_valid;
    logic              w_rd_capture;
    logic              w_rd_last;
    logic [RD_W-1:0]   w_rd_next;

    assign w_in_ready   = (r_state == c_S_LOAD);
    assign w_accept_in  = bus.in_valid & w_in_ready;
    assign w_rd_next    = r_rd_ptr + 1'b1;
    assign w_rd_capture = (r_state == c_S_READ) && (!w_out_valid || bus.out_ready)
                          && (r_rd_ptr < c_RD_END);
    // Once every neuron has been captured, the held beat is the last one.
    assign w_rd_last    = (r_state == c_S_READ) && w_out_valid && bus.out_ready
                          && (r_rd_ptr == c_RD_END);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= c_S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_write_en <= 1'b0;
            r_address  <= '0;
            r_data_in  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state  <= c_S_LOAD;
                        r_wr_ptr <= '0;
                    end
                end
                c_S_LOAD: begin
                    if (w_accept_in) begin
                        r_write_en <= 1'b1;
                        r_address  <= r_wr_ptr;
                        r_data_in  <= bus.in_data;
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == c_ADDR_LAST) begin
                            r_state <= c_S_SETTLE;
                        end
                    end
                end
                c_S_SETTLE: begin
                    r_address <= '0;
                    r_rd_ptr  <= '0;
                    r_state   <= c_S_READ;
                end
                c_S_READ: begin
                    if (w_rd_last) begin
                        r_done    <= 1'b1;
                        r_address <= '0;
                        r_state   <= c_S_IDLE;
                    end else if (w_rd_capture) begin
                        r_rd_ptr <= w_rd_next;
                        // Park on the last neuron rather than stepping into the weights.
                        if (r_rd_ptr != c_RD_LAST) begin
                            r_address <= ADDR_W'(w_rd_next);
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    sigmoid_readback_slice u_slice (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_load  (w_rd_capture),
        .i_data  (bus.reg_data_out),
        .i_ready (bus.out_ready),
        .o_data  (bus.out_data),
        .o_valid (w_out_valid)
    );

    assign bus.out_valid    = w_out_valid;
    assign bus.in_ready     = w_in_ready;
    assign bus.reg_write_en = r_write_en;
    assign bus.reg_address  = r_address;
    assign bus.reg_data_in  = r_data_in;
    assign busy             = (r_state != c_S_IDLE);
    assign done             = r_done;
endmodule

`default_nettype wire

// File: tb/tb_sigmoid_reg_sequencer.sv
//==============================================================================
// Module : tb_sigmoid_reg_sequencer
// Brief  : Directed self-checking bench with a behavioural register-file model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_sigmoid_reg_sequencer;
    logic clk;
    logic n_rst;
    logic start;
    logic busy;
    logic done;
    int   checks;
    int   errors;

    sigmoid_reg_sequencer_if u_if ();

    sigmoid_reg_sequencer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: written on the clock, read combinationally, 1111 out of range.
    logic [3:0] mem [0:31];
    always @(posedge clk) begin
        if (u_if.reg_write_en) mem[u_if.reg_address] <= u_if.reg_data_in;
    end
    assign u_if.reg_data_out = (u_if.reg_address < 5'd18) ? mem[u_if.reg_address] : 4'hF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dval(input logic [31:0] tbl, input int i);
        if (i < 8) return tbl[4*i +: 4];
        return 4'(i);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_we"},    32'(u_if.reg_write_en), 32'h0);
        chk({tag, "_addr"},  32'(u_if.reg_address),  32'h0);
        chk({tag, "_din"},   32'(u_if.reg_data_in),  32'h0);
        chk({tag, "_odata"}, 32'(u_if.out_data),     32'h0);
        chk({tag, "_oval"},  32'(u_if.out_valid),    32'h0);
        chk({tag, "_done"},  32'(done),              32'h0);
        chk({tag, "_busy"},  32'(busy),              32'h0);
        chk({tag, "_inrdy"}, 32'(u_if.in_ready),     32'h0);
    endtask

    // Full load job; in gapped mode every beat is followed by an idle cycle
    // and a stray start is pulsed in one of the gaps.
    task automatic load(input string tag, input logic [31:0] tbl, input bit gapped);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"},  32'(busy),          32'h1);
        chk({tag, "_inrdy"}, 32'(u_if.in_ready), 32'h1);
        for (int i = 0; i < 18; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = dval(tbl, i);
            step();
            chk($sformatf("%s_we%0d", tag, i),   32'(u_if.reg_write_en), 32'h1);
            chk($sformatf("%s_addr%0d", tag, i), 32'(u_if.reg_address),  32'(i));
            chk($sformatf("%s_din%0d", tag, i),  32'(u_if.reg_data_in),  32'(dval(tbl, i)));
            if (gapped && i < 17) begin
                u_if.in_valid = 1'b0;
                u_if.in_data  = ~dval(tbl, i);
                start = (i == 4);
                step();
                start = 1'b0;
                chk($sformatf("%s_gapwe%0d", tag, i),   32'(u_if.reg_write_en), 32'h0);
                chk($sformatf("%s_gapaddr%0d", tag, i), 32'(u_if.reg_address),  32'(i));
                chk($sformatf("%s_gaprdy%0d", tag, i),  32'(u_if.in_ready),     32'h1);
            end
        end
        u_if.in_valid = 1'b0;
        chk({tag, "_settle_rdy"}, 32'(u_if.in_ready), 32'h0);
        chk({tag, "_settle_bsy"}, 32'(busy),          32'h1);
        step();
        chk({tag, "_rd_we"},   32'(u_if.reg_write_en), 32'h0);
        chk({tag, "_rd_addr"}, 32'(u_if.reg_address),  32'h0);
        chk({tag, "_rd_oval"}, 32'(u_if.out_valid),    32'h0);
    endtask

    // Entered at READ entry; expects one beat per cycle except the stall window.
    task automatic readback(input string tag, input logic [31:0] vals,
                            input int stall_beat, input int stall_len);
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("%s_data%0d", tag, k), 32'(u_if.out_data),    32'(vals[4*k +: 4]));
            chk($sformatf("%s_val%0d", tag, k),  32'(u_if.out_valid),   32'h1);
            chk($sformatf("%s_addr%0d", tag, k), 32'(u_if.reg_address), 32'((k < 7) ? k + 1 : 7));
            chk($sformatf("%s_done%0d", tag, k), 32'(done),             32'h0);
            if (k == stall_beat) begin
                u_if.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    start = (s == 0);
                    step();
                    start = 1'b0;
                    chk($sformatf("%s_hold_data%0d", tag, s), 32'(u_if.out_data),    32'(vals[4*k +: 4]));
                    chk($sformatf("%s_hold_val%0d", tag, s),  32'(u_if.out_valid),   32'h1);
                    chk($sformatf("%s_hold_addr%0d", tag, s), 32'(u_if.reg_address), 32'(k + 1));
                end
                u_if.out_ready = 1'b1;
            end
        end
        step();
        chk({tag, "_done"},     32'(done),             32'h1);
        chk({tag, "_end_oval"}, 32'(u_if.out_valid),   32'h0);
        chk({tag, "_end_busy"}, 32'(busy),             32'h0);
        chk({tag, "_end_addr"}, 32'(u_if.reg_address), 32'h0);
        step();
        chk({tag, "_done_clr"}, 32'(done),             32'h0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        n_rst          = 1'b0;
        start          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = 4'h0;
        u_if.out_ready = 1'b0;
        step();
        step();
        check_idle("rst0");

        // Reset asserted mid-load while beat 5 is offered.
        n_rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = 4'(i);
            step();
        end
        chk("pre_rst_addr", 32'(u_if.reg_address), 32'h4);
        u_if.in_data = 4'h5;
        #1 n_rst = 1'b0;
        #1;
        check_idle("rst_mid");
        step();
        u_if.in_valid = 1'b0;
        n_rst = 1'b1;
        step();
        check_idle("rst_rel");

        // Streaming load of i%16 then readback of 0..7.
        load("stream", 32'h76543210, 1'b0);
        readback("rb0", 32'h76543210, -1, 0);

        // Gapped load with the neuron table, then full-throughput readback.
        load("gap", 32'hC710FA93, 1'b1);
        readback("rb1", 32'hC710FA93, -1, 0);

        // New job from IDLE after done, with backpressure on beat 2.
        load("job3", 32'hC710FA93, 1'b0);
        readback("bp", 32'hC710FA93, 2, 3);

        chk("final_busy", 32'(busy), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
